// File: rtl/data_mem_ctrl.sv
// Data-memory slave: word-organised SRAM with byte-lane stores and a wait-state
// load handshake. Define DMEM_MISALIGN_EN to reject misaligned accesses instead of masking them.
module data_mem_ctrl #(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stb,
    input  logic        i_wr_en,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wr_data,
    input  logic [1:0]  i_size,
    output logic        o_ack,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned ADR_W = IDX_W + 2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    // Masking the low bits keeps a misaligned access inside its naturally aligned container.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
`ifdef DMEM_MISALIGN_EN
        logic unused_size;
        unused_size = ^size;
        return addr;
`else
        case (size)
            SZ_BYTE: return addr;
            SZ_HALF: return {addr[31:1], 1'b0};
            default: return {addr[31:2], 2'b00};
        endcase
`endif
    endfunction

`ifdef DMEM_MISALIGN_EN
    function automatic logic is_misaligned(input logic [31:0] addr, input logic [1:0] size);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr[0];
            default: return addr[1:0] != 2'b00;
        endcase
    endfunction
`endif

    logic [31:0]      mem [DEPTH];

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [ADR_W-1:0] addr_q, addr_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic [31:0]      in_aligned;
    logic             unused_addr_hi;
    logic [ADR_W-1:0] rd_addr;
    logic [31:0]      rd_word;
    logic [31:0]      rd_shifted;

    logic             wr_fire;
    logic [3:0]       wr_be;
    logic [31:0]      wr_word;
    logic             store_req;

    assign in_aligned     = align_addr(i_addr, i_size);
    assign unused_addr_hi = ^in_aligned[31:ADR_W];
    assign store_req      = (state_q == IDLE) && !i_stb && i_wr_en && !rst;

    // Store lane selection; the write data is replicated so each lane sees its bytes.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        wr_be   = 4'b0000;
        wr_word = i_wr_data;
        case (i_size)
            SZ_BYTE: begin
                wr_be   = 4'b0001 << in_aligned[1:0];
                wr_word = {4{i_wr_data[7:0]}};
            end
            SZ_HALF: begin
                wr_be   = in_aligned[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{i_wr_data[15:0]}};
            end
            default: begin
                wr_be   = 4'b1111;
                wr_word = i_wr_data;
            end
        endcase
    end

`ifdef DMEM_MISALIGN_EN
    logic mis_q, mis_d;
    logic store_mis;

    assign store_mis    = store_req && is_misaligned(i_addr, i_size);
    assign wr_fire      = store_req && !store_mis;
    assign o_misaligned = store_mis || ((state_q == DONE) && mis_q);
`else
    assign wr_fire      = store_req;
    assign o_misaligned = 1'b0;
`endif

    // NOTE: the storage array has no reset; a reset term would stop it mapping onto SRAM.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem[in_aligned[ADR_W-1:2]][8*b +: 8] <= wr_word[8*b +: 8];
                end
            end
        end
    end

    // In IDLE the read comes straight off the request so LATENCY=1 needs no extra cycle.
    always_comb begin
        rd_addr    = (state_q == IDLE) ? in_aligned[ADR_W-1:0] : addr_q;
        rd_word    = mem[rd_addr[ADR_W-1:2]];
        rd_shifted = rd_word >> {rd_addr[1:0], 3'b000};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        rd_data_d = rd_data_q;
`ifdef DMEM_MISALIGN_EN
        mis_d     = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_stb) begin
                    addr_d = in_aligned[ADR_W-1:0];
                    cnt_d  = CNT_INIT;
`ifdef DMEM_MISALIGN_EN
                    mis_d  = is_misaligned(i_addr, i_size);
`endif
                    if (LATENCY == 1) begin
                        state_d   = DONE;
                        rd_data_d = rd_shifted;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d   = DONE;
                    rd_data_d = rd_shifted;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_q)
            IDLE:    o_ack = !i_stb;
            WAIT:    o_ack = 1'b0;
            DONE:    o_ack = 1'b1;
            default: o_ack = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            rd_data_q <= '0;
`ifdef DMEM_MISALIGN_EN
            mis_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            rd_data_q <= rd_data_d;
`ifdef DMEM_MISALIGN_EN
            mis_q     <= mis_d;
`endif
        end
    end

    assign o_rd_data = rd_data_q;

endmodule
